// File: rtl/anb_rd_arb.sv
// N-channel ANB read arbiter: round-robin address merge onto one SMC read port, id-routed data return.
// Optional protocol checker enabled by defining ANB_RD_ARB_ERR_EN.
module anb_rd_arb #(
  parameter int N         = 4,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 14,
  parameter int DATA_W    = 128,
  parameter int MAX_OUTST = 4,
  localparam int ID_W     = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N*ADDR_W-1:0]   m_addr,
  input  logic [N*LEN_W-1:0]    m_len,
  input  logic [N-1:0]          m_avalid,
  output logic [N-1:0]          m_aready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  output logic [N-1:0]          m_valid,
  input  logic [N-1:0]          m_ready,
  output logic [ID_W-1:0]       s_aid,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [LEN_W-1:0]      s_len,
  output logic                  s_avalid,
  input  logic                  s_aready,
  input  logic [ID_W-1:0]       s_id,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [DATA_W/8-1:0]   s_strb,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic                  err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic              s_avalid_q;
  logic [ID_W-1:0]   s_aid_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [LEN_W-1:0]  s_len_q;
  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   rr_d;
  logic [CNT_W-1:0]  cnt_q [N];
  logic [CNT_W-1:0]  cnt_d [N];

  logic              id_ok;
  logic              ready_at_id;
  logic [CNT_W-1:0]  cnt_at_id;
  logic              bad_beat;
  logic              beat_acc;
  logic [N-1:0]      dec;
  logic [N-1:0]      elig;
  logic              slot_load;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [ADDR_W-1:0] grant_addr;
  logic [LEN_W-1:0]  grant_len;
  logic              unused_strb;

  assign unused_strb = ^s_strb;

  // ---------------- data return path ----------------
  assign id_ok = ({1'b0, s_id} < (ID_W + 1)'(N));

  always_comb begin
    ready_at_id = 1'b1;
    cnt_at_id   = '0;
    for (int i = 0; i < N; i++) begin
      if (s_id == ID_W'(i)) begin
        ready_at_id = m_ready[i];
        cnt_at_id   = cnt_q[i];
      end
    end
  end

`ifdef ANB_RD_ARB_ERR_EN
  assign bad_beat = s_valid && (!id_ok || (s_last && (cnt_at_id == '0)));
`else
  assign bad_beat = s_valid && !id_ok;
`endif

  // Flagged beats are swallowed so a broken id can never stall the SMC.
  assign s_ready  = bad_beat ? 1'b1 : ready_at_id;
  assign beat_acc = s_valid && s_ready;
  assign m_data   = s_data;
  assign m_last   = s_last;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign m_valid[gi] = s_valid && !bad_beat && (s_id == ID_W'(gi));
    assign dec[gi]     = beat_acc && s_last && id_ok && (s_id == ID_W'(gi)) && (cnt_q[gi] != '0);
    // A retiring burst frees its slot in the same cycle.
    assign elig[gi]    = m_avalid[gi] && ((cnt_q[gi] < CNT_MAX) || dec[gi]);
  end

  // ---------------- address arbitration ----------------
  assign slot_load = !s_avalid_q || s_aready;

  always_comb begin
    int j;
    j          = 0;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_addr = '0;
    grant_len  = '0;
    // Scan downward so the candidate closest to the pointer is written last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= N) j = j - N;
      if (elig[j]) begin
        grant_vld  = 1'b1;
        grant_idx  = ID_W'(j);
        grant_addr = m_addr[j*ADDR_W +: ADDR_W];
        grant_len  = m_len[j*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    m_aready = '0;
    if (slot_load && grant_vld) m_aready[grant_idx] = 1'b1;
  end

  assign rr_d = (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (m_aready[i] && !dec[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!m_aready[i] && dec[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_avalid_q <= 1'b0;
      s_aid_q    <= '0;
      s_addr_q   <= '0;
      s_len_q    <= '0;
      rr_q       <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      if (slot_load) begin
        if (grant_vld) begin
          s_avalid_q <= 1'b1;
          s_aid_q    <= grant_idx;
          s_addr_q   <= grant_addr;
          s_len_q    <= grant_len;
          rr_q       <= rr_d;
        end else begin
          s_avalid_q <= 1'b0;
        end
      end
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign s_avalid = s_avalid_q;
  assign s_aid    = s_aid_q;
  assign s_addr   = s_addr_q;
  assign s_len    = s_len_q;

  // ---------------- protocol checker ----------------
`ifdef ANB_RD_ARB_ERR_EN
  logic err_q;
  logic err_d;
  logic cnt_over;

  always_comb begin
    cnt_over = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q[i] > CNT_MAX) cnt_over = 1'b1;
    end
  end

  assign err_d = err_q || (beat_acc && bad_beat) || cnt_over;

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_anb_rd_arb.sv
// Directed bench for anb_rd_arb (N=4, MAX_OUTST=2); expectations follow ANB_RD_ARB_ERR_EN.
module tb_anb_rd_arb;
  localparam int N      = 4;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 14;
  localparam int DATA_W = 128;
  localparam int ID_W   = 2;

`ifdef ANB_RD_ARB_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N*ADDR_W-1:0] m_addr;
  logic [N*LEN_W-1:0]  m_len;
  logic [N-1:0]        m_avalid;
  logic [N-1:0]        m_aready;
  logic [DATA_W-1:0]   m_data;
  logic                m_last;
  logic [N-1:0]        m_valid;
  logic [N-1:0]        m_ready;
  logic [ID_W-1:0]     s_aid;
  logic [ADDR_W-1:0]   s_addr;
  logic [LEN_W-1:0]    s_len;
  logic                s_avalid;
  logic                s_aready;
  logic [ID_W-1:0]     s_id;
  logic [DATA_W-1:0]   s_data;
  logic [DATA_W/8-1:0] s_strb;
  logic                s_valid;
  logic                s_ready;
  logic                s_last;
  logic                err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  anb_rd_arb #(.N(N), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .MAX_OUTST(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_addr(m_addr), .m_len(m_len), .m_avalid(m_avalid), .m_aready(m_aready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .s_aid(s_aid), .s_addr(s_addr), .s_len(s_len), .s_avalid(s_avalid), .s_aready(s_aready),
    .s_id(s_id), .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .err(err)
  );

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return 64'hA0 + 64'(i);
  endfunction

  function automatic logic [LEN_W-1:0] len_of(input int i);
    return 14'd16 + 14'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h", tag, obs);
  endtask

  task automatic beat(input logic [ID_W-1:0] id, input logic last, input logic [DATA_W-1:0] d);
    s_valid = 1'b1;
    s_id    = id;
    s_last  = last;
    s_data  = d;
  endtask

  initial begin
    rst_n = 1'b0; m_avalid = '0; m_ready = '0; s_aready = 1'b0;
    s_id = '0; s_data = '0; s_strb = '1; s_valid = 1'b0; s_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
      m_len[i*LEN_W +: LEN_W]    = len_of(i);
    end
    repeat (3) tick();
    chk("rst_avalid", s_avalid, 0);
    chk("rst_aid", s_aid, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_len", s_len, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // Fairness: every channel requesting, two grants each until full.
    m_avalid = 4'hF; s_aready = 1'b1; #1;
    chk("fair_first_ar", m_aready, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("fair_avalid_%0d", k), s_avalid, 1);
      chk($sformatf("fair_aid_%0d", k), s_aid, k % 4);
      chk($sformatf("fair_addr_%0d", k), s_addr, addr_of(k % 4));
      chk($sformatf("fair_ar_%0d", k), m_aready, (k < 7) ? (4'b0001 << ((k + 1) % 4)) : 4'b0000);
    end
    m_avalid = 4'b0010;
    tick();
    chk("fair_drain", s_avalid, 0);

    // Outstanding limit on channel 1, freed by the last beat of a 4-beat burst.
    m_ready = 4'hF; #1;
    chk("lim_blocked", m_aready, 4'b0000);
    for (int b = 0; b < 4; b++) begin
      beat(2'd1, (b == 3), 128'h1111_0000 + 128'(b)); #1;
      chk($sformatf("lim_mv_%0d", b), m_valid, 4'b0010);
      chk($sformatf("lim_sr_%0d", b), s_ready, 1);
      chk($sformatf("lim_data_%0d", b), m_data, 128'h1111_0000 + 128'(b));
      chk($sformatf("lim_ar_%0d", b), m_aready, (b == 3) ? 4'b0010 : 4'b0000);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0; #1;
    chk("lim_full_again", m_aready, 4'b0000);
    chk("lim_aid", s_aid, 1);
    chk("lim_avalid", s_avalid, 1);
    m_avalid = 4'b0000;
    tick();

    // Data routing: interleaved ids 0 and 3, channel 3 stalled for two cycles.
    m_ready = 4'b0111;
    beat(2'd0, 1'b0, 128'hD1); #1;
    chk("rt_mv_d1", m_valid, 4'b0001);
    chk("rt_sr_d1", s_ready, 1);
    chk("rt_data_d1", m_data, 128'hD1);
    chk("rt_avalid_idle", s_avalid, 0);
    tick();
    beat(2'd3, 1'b0, 128'hD2); #1;
    chk("rt_mv_d2a", m_valid, 4'b1000);
    chk("rt_sr_d2a", s_ready, 0);
    tick();
    chk("rt_sr_d2b", s_ready, 0);
    m_ready = 4'hF; #1;
    chk("rt_sr_d2c", s_ready, 1);
    chk("rt_data_d2", m_data, 128'hD2);
    tick();
    beat(2'd0, 1'b1, 128'hD3); #1;
    chk("rt_mv_d3", m_valid, 4'b0001);
    chk("rt_last_d3", m_last, 1);
    tick();
    beat(2'd3, 1'b1, 128'hD4); #1;
    chk("rt_mv_d4", m_valid, 4'b1000);
    chk("rt_sr_d4", s_ready, 1);
    tick();
    beat(2'd2, 1'b1, 128'hD5); #1;
    chk("rt_mv_d5", m_valid, 4'b0100);
    tick();
    s_valid = 1'b0; s_last = 1'b0;

    // Backpressure: channel 2 in the slot, SMC stalls for five cycles.
    m_avalid = 4'b0100; s_aready = 1'b0; #1;
    chk("bp_grant2", m_aready, 4'b0100);
    tick();
    m_avalid = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_ar_%0d", c), m_aready, 4'b0000);
      chk($sformatf("bp_aid_%0d", c), s_aid, 2);
      chk($sformatf("bp_addr_%0d", c), s_addr, addr_of(2));
      chk($sformatf("bp_len_%0d", c), s_len, len_of(2));
      chk($sformatf("bp_avalid_%0d", c), s_avalid, 1);
      tick();
    end
    s_aready = 1'b1; #1;
    chk("bp_resume_ar", m_aready, 4'b1000);
    tick();
    chk("bp_aid3", s_aid, 3);
    chk("bp_addr3", s_addr, addr_of(3));
    chk("bp_next_ar", m_aready, 4'b0001);

    // Simultaneous grant and retire on channel 0 (counter 1 stays 1).
    beat(2'd0, 1'b1, 128'hD6); #1;
    chk("sim_ar", m_aready, 4'b0001);
    chk("sim_mv", m_valid, 4'b0001);
    tick();
    s_valid = 1'b0; s_last = 1'b0; m_avalid = 4'b0001; #1;
    chk("sim_aid", s_aid, 0);
    chk("sim_cnt_below_max", m_aready, 4'b0001);
    tick();
    chk("sim_cnt_full", m_aready, 4'b0000);
    m_avalid = 4'b0000;
    tick();
    chk("sim_drain", s_avalid, 0);

    // Error: retire channel 2 twice, then a last beat with its counter at 0.
    beat(2'd2, 1'b1, 128'hD7); tick();
    beat(2'd2, 1'b1, 128'hD8); tick();
    m_ready = 4'b1011;
    beat(2'd2, 1'b1, 128'hD9); #1;
    chk("err_mv", m_valid, ERR_ON ? 4'b0000 : 4'b0100);
    chk("err_sr", s_ready, ERR_ON ? 1 : 0);
    chk("err_before", err, 0);
    tick();
    s_valid = 1'b0; s_last = 1'b0; #1;
    chk("err_set", err, ERR_ON);
    tick(); tick();
    chk("err_sticky", err, ERR_ON);
    m_ready = 4'hF;
    beat(2'd2, 1'b1, 128'hDA); tick();
    s_valid = 1'b0; s_last = 1'b0; m_avalid = 4'b0100; #1;
    chk("uf_ar0", m_aready, 4'b0100);
    tick();
    chk("uf_ar1", m_aready, 4'b0100);
    tick();
    chk("uf_full", m_aready, 4'b0000);
    chk("uf_err_held", err, ERR_ON);

    // Reset mid-traffic clears everything.
    rst_n = 1'b0;
    tick();
    chk("rst2_avalid", s_avalid, 0);
    chk("rst2_err", err, 0);
    chk("rst2_addr", s_addr, 0);
    rst_n = 1'b1; #1;
    chk("rst2_cnt_clear", m_aready, 4'b0100);
    m_avalid = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
